// File: rtl/sng_pkg.sv
// sng_pkg: shared state type and bit-selection helpers for the FSM-MUX stochastic number generator
package sng_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int tz(input logic [31:0] n, input int w);
    logic [31:0] m;
    logic hit;
    int t;
    m = n;
    hit = 1'b0;
    t = 0;
    for (int i = 0; i < 32; i++) begin
      if (!hit && i <= w) begin
        if (m[0]) hit = 1'b1;
        else begin
          t++;
          m = m >> 1;
        end
      end
    end
    return t;
  endfunction
  function automatic logic [31:0] bip_map(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/sng_fsm_mux_sel.sv
// sng_fsm_mux_sel: picks one operand bit per cycle from the trailing-zero count of (counter+1)
module sng_fsm_mux_sel import sng_pkg::*; #(
  parameter int W = 4
) (
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] x_i,
  input  logic         bipolar_i,
  input  logic [W-1:0] off_i,
  output logic         bit_o
);
  logic [W-1:0] ck, xe, sh;
  logic [W:0] n;
  int t;
  always_comb begin
    ck = c_i + off_i;
    n = {1'b0, ck} + (W+1)'(1);
    xe = bipolar_i ? W'(bip_map(32'(x_i), W)) : x_i;
    t = tz(32'(n), W);
    sh = xe >> (W - 1 - t);
    bit_o = (t < W) & sh[0];
  end
endmodule

// File: rtl/sng_fsm_mux_mc.sv
// sng_fsm_mux_mc: multi-channel FSM-MUX stochastic number generator with shared period counter
module sng_fsm_mux_mc import sng_pkg::*; #(
  parameter int W = 4,
  parameter int CH = 4,
  parameter int PHASE_STEP = 5
) (
  input  logic          i_clk_sng_fsm_mux_mc,
  input  logic          i_rst_sng_fsm_mux_mc,
  input  logic [CH*W-1:0] i_x_bn,
  input  logic          i_start_sng_fsm_mux_mc,
  input  logic          i_stop_sng_fsm_mux_mc,
  input  logic          i_bipolar,
  input  logic          i_phase_en,
  output logic [CH-1:0] o_sn_bits,
  output logic          o_sn_valid,
  output logic          o_done,
  output logic          o_busy
);
  state_e state_q, state_d;
  logic [W-1:0] c_q, c_d;
  logic [CH*W-1:0] x_q, x_s;
  logic bip_q, ph_q, bip_s, ph_s, ld;
  logic [CH-1:0] sn_q, sn_d, sel;
  logic done_q, done_d;
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    ld = 1'b0;
    if (state_q == IDLE) begin
      if (i_start_sng_fsm_mux_mc && !i_stop_sng_fsm_mux_mc) begin
        state_d = RUN;
        c_d = '0;
        ld = 1'b1;
      end
    end else if (i_stop_sng_fsm_mux_mc) state_d = IDLE;
    else if (c_q == '1) begin
      // a start on the last edge restarts without a bubble
      if (i_start_sng_fsm_mux_mc) begin
        c_d = '0;
        ld = 1'b1;
      end else state_d = IDLE;
    end else c_d = c_q + W'(1);
    x_s = ld ? i_x_bn : x_q;
    bip_s = ld ? i_bipolar : bip_q;
    ph_s = ld ? i_phase_en : ph_q;
    sn_d = (state_d == RUN) ? sel : '0;
    done_d = (state_d == RUN) && (c_d == '1);
  end
  for (genvar k = 0; k < CH; k++) begin : g_ch
    sng_fsm_mux_sel #(.W(W)) u_sel (
      .c_i(c_d),
      .x_i(x_s[k*W +: W]),
      .bipolar_i(bip_s),
      .off_i(ph_s ? W'(k * PHASE_STEP) : '0),
      .bit_o(sel[k])
    );
  end
  always_ff @(posedge i_clk_sng_fsm_mux_mc) begin
    if (i_rst_sng_fsm_mux_mc) begin
      state_q <= IDLE;
      c_q <= '0;
      x_q <= '0;
      bip_q <= 1'b0;
      ph_q <= 1'b0;
      sn_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      if (ld) begin
        x_q <= i_x_bn;
        bip_q <= i_bipolar;
        ph_q <= i_phase_en;
      end
      sn_q <= sn_d;
      done_q <= done_d;
    end
  end
  assign o_sn_bits = sn_q;
  assign o_done = done_q;
  assign o_sn_valid = (state_q == RUN);
  assign o_busy = (state_q == RUN);
endmodule

// File: tb/tb_sng_fsm_mux_mc.sv
// tb_sng_fsm_mux_mc: directed and randomized checks of the multi-channel SNG against a behavioural model
module tb_sng_fsm_mux_mc;
  localparam int W = 4, CH = 4, PS = 5, P = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, bip = 1'b0, ph = 1'b0;
  logic [CH*W-1:0] x = '0;
  logic [CH-1:0] sn_bits;
  logic sn_valid, done, busy;
  int checks = 0, errors = 0;
  sng_fsm_mux_mc #(.W(W), .CH(CH), .PHASE_STEP(PS)) dut (
    .i_clk_sng_fsm_mux_mc(clk),
    .i_rst_sng_fsm_mux_mc(rst),
    .i_x_bn(x),
    .i_start_sng_fsm_mux_mc(start),
    .i_stop_sng_fsm_mux_mc(stop),
    .i_bipolar(bip),
    .i_phase_en(ph),
    .o_sn_bits(sn_bits),
    .o_sn_valid(sn_valid),
    .o_done(done),
    .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: expected stream bit straight from the signed-value / trailing-zero rule
  function automatic bit ref_bit(input int xv, input bit b, input int ck);
    int v, n, t;
    v = b ? ((xv >= P/2) ? xv - P : xv) + P/2 : xv;
    n = ck + 1;
    t = 0;
    while (n % 2 == 0) begin
      n = n / 2;
      t++;
    end
    return (t < W) ? bit'((v >> (W - 1 - t)) & 1) : 1'b0;
  endfunction
  bit m_run = 0, m_bip = 0, m_ph = 0, armed = 0;
  int m_c = 0;
  int m_x[CH];
  task automatic m_latch();
    m_run = 1;
    m_c = 0;
    m_bip = bip;
    m_ph = ph;
    for (int k = 0; k < CH; k++) m_x[k] = int'(x[k*W +: W]);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0;
      m_c = 0;
      m_bip = 0;
      m_ph = 0;
      for (int k = 0; k < CH; k++) m_x[k] = 0;
      armed = 1;
    end else if (!m_run) begin
      if (start && !stop) m_latch();
    end else if (stop) m_run = 0;
    else if (m_c == P - 1) begin
      if (start) m_latch();
      else m_run = 0;
    end else m_c++;
  end
  logic [P-1:0] cap[CH], lcap[CH];
  int ones[CH], lones[CH];
  int run = 0, maxrun = 0, ndone = 0;
  always @(negedge clk) begin
    if (armed) begin
      logic [CH-1:0] eb;
      for (int k = 0; k < CH; k++)
        eb[k] = m_run && ref_bit(m_x[k], m_bip, (m_c + (m_ph ? k * PS : 0)) % P);
      chk("valid", 32'(sn_valid), 32'(m_run));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_run && m_c == P - 1));
      chk("bits", 32'(sn_bits), 32'(eb));
      if (m_run) begin
        for (int k = 0; k < CH; k++) begin
          cap[k] = (m_c == 0) ? P'(sn_bits[k]) : {cap[k][P-2:0], sn_bits[k]};
          ones[k] = ((m_c == 0) ? 0 : ones[k]) + int'(sn_bits[k]);
        end
        if (m_c == P - 1) begin
          lcap = cap;
          lones = ones;
        end
      end
      if (sn_valid === 1'b1) run++;
      else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      if (done === 1'b1) ndone++;
    end
  end
  function automatic logic [CH*W-1:0] rep(input logic [W-1:0] v);
    return {CH{v}};
  endfunction
  task automatic go(input logic [CH*W-1:0] xv, input logic b, input logic p);
    @(negedge clk);
    x = xv;
    bip = b;
    ph = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    maxrun = 0;
    ndone = 0;
    repeat (16) begin
      x = CH*W'($urandom);
      bip = 1'($urandom);
      ph = 1'($urandom);
      @(negedge clk);
    end
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(sn_valid), 0);
    chk("rst_bits", 32'(sn_bits), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    for (int v = 0; v < P; v++) begin
      go(rep(W'(v)), 1'b0, 1'b0);
      for (int k = 0; k < CH; k++) chk("sweep_ones", lones[k], v);
      chk("sweep_len", maxrun, 16);
      chk("sweep_ndone", ndone, 1);
      if (v == 8) chk("x8_stream", 32'(lcap[0]), 32'h0000AAAA);
      if (v == 15) chk("x15_stream", 32'(lcap[0]), 32'h0000FFFE);
      if (v == 0) chk("x0_stream", 32'(lcap[0]), 32'h00000000);
    end
    go(rep(4'b1000), 1'b1, 1'b0);
    chk("bip_m8_ones", lones[0], 0);
    go(rep(4'b0111), 1'b1, 1'b0);
    chk("bip_p7_ones", lones[0], 15);
    go(rep(4'b0000), 1'b1, 1'b0);
    chk("bip_0_stream", 32'(lcap[0]), 32'h0000AAAA);
    go(rep(4'd8), 1'b0, 1'b1);
    chk("ph_ch0", 32'(lcap[0]), 32'h0000AAAA);
    chk("ph_ch1", 32'(lcap[1]), 32'h00005555);
    for (int k = 0; k < CH; k++) chk("ph_ones", lones[k], 8);
    @(negedge clk);
    x = rep(4'd3);
    bip = 1'b0;
    ph = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    maxrun = 0;
    ndone = 0;
    repeat (15) @(negedge clk);
    x = rep(4'd12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    chk("b2b_len", maxrun, 32);
    chk("b2b_ones", lones[0], 12);
    chk("b2b_ndone", ndone, 2);
    @(negedge clk);
    x = rep(4'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    #1;
    stop = 1'b0;
    chk("abort_valid", 32'(sn_valid), 0);
    chk("abort_done", 32'(done), 0);
    repeat (20) @(negedge clk);
    chk("abort_ndone", ndone, 0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 32'(busy), 0);
    @(negedge clk);
    x = rep(4'd8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_valid", 32'(sn_valid), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_bits", 32'(sn_bits), 0);
    go(rep(4'd8), 1'b0, 1'b0);
    chk("rstmid_stream", 32'(lcap[0]), 32'h0000AAAA);
    chk("rstmid_len", maxrun, 16);
    repeat (800) begin
      @(negedge clk);
      x = CH*W'($urandom);
      bip = 1'($urandom);
      ph = 1'($urandom);
      start = ($urandom % 4) == 0;
      stop = ($urandom % 24) == 0;
      rst = ($urandom % 90) == 0;
    end
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sng_fsm_mux_mc.md
Name: sng_fsm_mux_mc

Overview:
Multi-channel, parametrised FSM-MUX stochastic number generator (SNG). It converts CH binary operands of W bits each into deterministic stochastic bit-streams of length 2^W. All channels share one period counter. Successor to the single-channel 4-bit FSM-MUX: it adds generic width, channel count, a bipolar mode, per-channel phase decorrelation, valid/done handshake and back-to-back restart. It feeds the stochastic DCNN datapath (SC multipliers/adders) in nn_wraper.

Parameters:
W, 4, operand width; stream period 2^W cycles
CH, 4, number of independent channels
PHASE_STEP, 5, counter offset added per channel index when phase mode is enabled (mod 2^W)

Ports:
i_clk_sng_fsm_mux_mc  in  1  clock, rising edge
i_rst_sng_fsm_mux_mc  in  1  reset, synchronous, active-high
i_x_bn  in  CH*W  packed operands; channel k occupies bits [k*W +: W]
i_start_sng_fsm_mux_mc  in  1  start request; latches i_x_bn and the mode inputs
i_stop_sng_fsm_mux_mc  in  1  abort the current stream
i_bipolar  in  1  1: operands are two's complement (bipolar SC); 0: unsigned (unipolar)
i_phase_en  in  1  1: channel k uses counter offset k*PHASE_STEP
o_sn_bits  out  CH  stochastic bit, one per channel
o_sn_valid  out  1  o_sn_bits carries a stream bit this cycle
o_done  out  1  single-cycle pulse coincident with the last bit (c = 2^W-1)
o_busy  out  1  state is RUN

Behaviour:
- Reset: synchronous, active-high, highest priority. State goes to IDLE; counter, latched operands and latched modes clear to 0; all outputs are 0.
- States: IDLE, RUN. Counter c is W bits. All outputs are registered.
- IDLE with start=1 and stop=0 sampled at edge t:
  - latch x, bipolar, phase_en; set c=0; go to RUN.
  - o_sn_valid=1 in cycle t+1 with the bit for c=0.
- RUN: c increments every cycle; exactly 2^W valid cycles are produced.
  - o_done=1 together with the bit for c=2^W-1.
  - Next state is IDLE, unless start=1 on that same last edge. In that case: re-latch, c wraps to 0, stay in RUN, no bubble (o_sn_valid stays 1).
- Start during RUN on any edge other than the last is ignored.
- Stop sampled in RUN: go to IDLE at that edge; o_sn_valid, o_done and o_busy are 0 next cycle; no o_done for the aborted stream.
- Stop has priority over start. Stop in IDLE has no effect.
- Bit selection, per channel k:
  - effective operand xe = x_k with MSB inverted if bipolar, else x_k.
  - counter ck = (c + (phase_en ? k*PHASE_STEP : 0)) mod 2^W.
  - n = ck+1 computed in W+1 bits; t = trailing-zero count of n.
  - If t = W, output 0; else output xe[W-1-t].
  - Guarantee: each full period carries exactly xe ones, for any phase.
- Operand inputs are don't-care except at the latching edge. Mode changes mid-stream have no effect.

Decomposition:
- Package sng_pkg:
  - state enum {IDLE, RUN}
  - function tz(n, W) returning the trailing-zero count
  - function bip_map (MSB invert)
- Sub-module sng_fsm_mux_sel, combinational, instantiated CH times.
  - Inputs: counter, latched operand, bipolar, phase offset.
  - Output: one stream bit.
- Top holds the FSM, the counter, the operand/mode latches and the output registers.

Test Plan:
1. W=4, CH=1, unipolar, phase off, sweep x=0..15: each stream has exactly x ones. Exact streams: x=8 gives 1010101010101010; x=15 gives 1111111111111110; x=0 gives all zeros. o_done is high only on the 16th valid cycle.
2. Bipolar: x=4'b1000 (-8) gives 0 ones; x=4'b0111 (+7) gives 15 ones; x=0 gives 1010101010101010 (p=0.5).
3. CH=4, phase on, PHASE_STEP=5, all x=8: ch0 stream is 1010...; ch1 is the ch0 stream rotated by 5 (0101...). Every channel has 8 ones over 16 cycles.
4. Back-to-back: start with x=3; reassert start with x=12 on the o_done cycle. o_sn_valid stays high for 32 consecutive cycles; the second period has 12 ones.
5. Abort and priority: stop at cycle 6 of RUN gives o_sn_valid=0 next cycle and no o_done. Start and stop asserted together in IDLE leave the block in IDLE.
6. Reset mid-RUN at cycle 9: all outputs are 0 next cycle and state is IDLE. A following start produces a clean 16-cycle stream from c=0.
